// File: rtl/inst_buffer_pkg.sv
// Shared widths, storage entry type and helpers for the instruction buffer.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package inst_buffer_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 64;

    // Word driven to decode on an unoccupied output slot.
    localparam logic [INST_W-1:0] NOOP = '0;

    // One stored instruction together with its fetch PC.
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } ib_entry_t;

    // Decode can consume at most two per cycle; code 3 means "as many as possible".
    function automatic logic [1:0] sat_take(input logic [1:0] take);
        return (take == 2'd3) ? 2'd2 : take;
    endfunction

endpackage

// File: rtl/inst_buffer_ram.sv
// Entry storage: DEPTH entries, two write ports, two asynchronous read ports.
// Latency: write visible on reads after the write edge; reads are combinational.
// Backpressure: none; the controller only writes slots it knows are free.
module ib_ram
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clock,
    input  logic             wr0_en_i,
    input  logic [PTR_W-1:0] wr0_addr_i,
    input  ib_entry_t        wr0_dat_i,
    input  logic             wr1_en_i,
    input  logic [PTR_W-1:0] wr1_addr_i,
    input  ib_entry_t        wr1_dat_i,
    input  logic [PTR_W-1:0] rd0_addr_i,
    output ib_entry_t        rd0_dat_o,
    input  logic [PTR_W-1:0] rd1_addr_i,
    output ib_entry_t        rd1_dat_o
);

    ib_entry_t mem_q [DEPTH];

    // Both ports target consecutive slots, so they never collide in normal use.
    always_ff @(posedge clock) begin
        if (wr0_en_i) mem_q[wr0_addr_i] <= wr0_dat_i;
        if (wr1_en_i) mem_q[wr1_addr_i] <= wr1_dat_i;
    end

    assign rd0_dat_o = mem_q[rd0_addr_i];
    assign rd1_dat_o = mem_q[rd1_addr_i];

endmodule

// File: rtl/inst_buffer.sv
// 2-wide in-order instruction queue between fetch and decode, with fetch throttles.
// Latency: 1 cycle from enqueue edge to output; no same-cycle bypass.
// Backpressure: non_ins_en/one_ins_en throttle fetch; excess enqueue dropped and flagged.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [INST_W-1:0] if_IRA_in,
    input  logic [INST_W-1:0] if_IRB_in,
    input  logic [PC_W-1:0]   if_PCA_in,
    input  logic [PC_W-1:0]   if_PCB_in,
    input  logic              if_valid_instA_in,
    input  logic              if_valid_instB_in,
    input  logic [1:0]        id_take_cnt_in,
    input  logic              flush_in,
    output logic [INST_W-1:0] ib_IRA_out,
    output logic [INST_W-1:0] ib_IRB_out,
    output logic [PC_W-1:0]   ib_PCA_out,
    output logic [PC_W-1:0]   ib_PCB_out,
    output logic              ib_valid_instA_out,
    output logic              ib_valid_instB_out,
    output logic              non_ins_en_out,
    output logic              one_ins_en_out,
    output logic              overflow_err_out
);

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             ovf_q, ovf_d;

    logic [PTR_W:0]   free;
    logic [1:0]       n_req, n_enq, take, n_deq;
    logic             we0, we1;
    logic [PTR_W-1:0] head_p1, tail_p1;
    ib_entry_t        wdat0, wdat1, rdat0, rdat1;

    // Free space is judged on the pre-edge count; slots freed this cycle are not reused.
    assign free    = DEPTH_CNT - count_q;
    assign n_req   = {1'b0, if_valid_instA_in} + {1'b0, if_valid_instB_in};
    assign take    = sat_take(id_take_cnt_in);
    assign head_p1 = head_q + PTR_W'(1);
    assign tail_p1 = tail_q + PTR_W'(1);

    // Valid instructions are packed at the tail in program order; a lone B lands at the tail.
    assign wdat0 = if_valid_instA_in ? ib_entry_t'{inst: if_IRA_in, pc: if_PCA_in}
                                     : ib_entry_t'{inst: if_IRB_in, pc: if_PCB_in};
    assign wdat1 = ib_entry_t'{inst: if_IRB_in, pc: if_PCB_in};

    // Size the enqueue/dequeue for this cycle and derive next pointers, count and error flag.
    always_comb begin
        n_enq   = n_req;
        n_deq   = take;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        we0     = 1'b0;
        we1     = 1'b0;
        if ((PTR_W+1)'(n_req) > free) n_enq = free[1:0];
        if ((PTR_W+1)'(take) > count_q) n_deq = count_q[1:0];
        if (flush_in) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            we0     = (n_enq != 2'd0);
            we1     = (n_enq == 2'd2);
            head_d  = head_q + PTR_W'(n_deq);
            tail_d  = tail_q + PTR_W'(n_enq);
            count_d = count_q + (PTR_W+1)'(n_enq) - (PTR_W+1)'(n_deq);
            if (n_req > n_enq) ovf_d = 1'b1;
        end
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    ib_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
        .clock      (clock),
        .wr0_en_i   (we0),
        .wr0_addr_i (tail_q),
        .wr0_dat_i  (wdat0),
        .wr1_en_i   (we1),
        .wr1_addr_i (tail_p1),
        .wr1_dat_i  (wdat1),
        .rd0_addr_i (head_q),
        .rd0_dat_o  (rdat0),
        .rd1_addr_i (head_p1),
        .rd1_dat_o  (rdat1)
    );

    // Outputs depend on registered state only; empty slots present zeros.
    assign ib_valid_instA_out = (count_q != '0);
    assign ib_valid_instB_out = (count_q >= (PTR_W+1)'(2));
    assign ib_IRA_out         = ib_valid_instA_out ? rdat0.inst : NOOP;
    assign ib_IRB_out         = ib_valid_instB_out ? rdat1.inst : NOOP;
    assign ib_PCA_out         = ib_valid_instA_out ? rdat0.pc : '0;
    assign ib_PCB_out         = ib_valid_instB_out ? rdat1.pc : '0;
    assign non_ins_en_out     = (free == '0);
    assign one_ins_en_out     = (free == (PTR_W+1)'(1));
    assign overflow_err_out   = ovf_q;

endmodule

// File: tb/tb_inst_buffer.sv
// Randomized plus directed bench for inst_buffer with a queue-based reference model.
// Latency: expected state pushed after each edge, compared at the following negedge.
// Backpressure: stimulus mostly honours the throttles, occasionally over-enqueues.
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam int DEPTH = 8;

    logic              clock = 1'b1;
    logic              reset;
    logic [INST_W-1:0] if_IRA_in, if_IRB_in;
    logic [PC_W-1:0]   if_PCA_in, if_PCB_in;
    logic              if_valid_instA_in, if_valid_instB_in;
    logic [1:0]        id_take_cnt_in;
    logic              flush_in;
    logic [INST_W-1:0] ib_IRA_out, ib_IRB_out;
    logic [PC_W-1:0]   ib_PCA_out, ib_PCB_out;
    logic              ib_valid_instA_out, ib_valid_instB_out;
    logic              non_ins_en_out, one_ins_en_out, overflow_err_out;

    always #5 clock = ~clock;

    inst_buffer #(.DEPTH(DEPTH), .PTR_W(3)) dut (
        .clock              (clock),
        .reset              (reset),
        .if_IRA_in          (if_IRA_in),
        .if_IRB_in          (if_IRB_in),
        .if_PCA_in          (if_PCA_in),
        .if_PCB_in          (if_PCB_in),
        .if_valid_instA_in  (if_valid_instA_in),
        .if_valid_instB_in  (if_valid_instB_in),
        .id_take_cnt_in     (id_take_cnt_in),
        .flush_in           (flush_in),
        .ib_IRA_out         (ib_IRA_out),
        .ib_IRB_out         (ib_IRB_out),
        .ib_PCA_out         (ib_PCA_out),
        .ib_PCB_out         (ib_PCB_out),
        .ib_valid_instA_out (ib_valid_instA_out),
        .ib_valid_instB_out (ib_valid_instB_out),
        .non_ins_en_out     (non_ins_en_out),
        .one_ins_en_out     (one_ins_en_out),
        .overflow_err_out   (overflow_err_out)
    );

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } ent_t;

    typedef struct {
        bit          va, vb, non, one, ovf;
        logic [31:0] ira, irb;
        logic [63:0] pca, pcb;
    } snap_t;

    ent_t        mdl_q[$];
    bit          mdl_ovf;
    snap_t       exp_q[$];
    int          pass_cnt = 0;
    int          chk_cnt  = 0;
    logic [63:0] pc_ctr   = 64'h0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    endtask

    // Expected outputs derived from the model queue contents.
    function automatic snap_t mdl_snap();
        snap_t s;
        int    n;
        n     = mdl_q.size();
        s.va  = (n >= 1);
        s.vb  = (n >= 2);
        s.ira = '0; s.pca = '0; s.irb = '0; s.pcb = '0;
        if (s.va) begin s.ira = mdl_q[0].inst; s.pca = mdl_q[0].pc; end
        if (s.vb) begin s.irb = mdl_q[1].inst; s.pcb = mdl_q[1].pc; end
        s.non = (n == DEPTH);
        s.one = (n == DEPTH - 1);
        s.ovf = mdl_ovf;
        return s;
    endfunction

    // One clock edge of the reference model.
    task automatic mdl_edge(input bit a, input bit b, input ent_t ea, input ent_t eb,
                            input int take, input bit fl);
        int   n, free, deq;
        ent_t inc[$];
        if (fl) begin
            mdl_q.delete();
            return;
        end
        n    = mdl_q.size();
        free = DEPTH - n;
        if (a) inc.push_back(ea);
        if (b) inc.push_back(eb);
        if (inc.size() > free) mdl_ovf = 1'b1;
        deq = (take > 2) ? 2 : take;
        if (deq > n) deq = n;
        repeat (deq) void'(mdl_q.pop_front());
        for (int i = 0; i < inc.size() && i < free; i++) mdl_q.push_back(inc[i]);
    endtask

    task automatic step(input bit a, input bit b, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [63:0] pa, input logic [63:0] pb, input int take, input bit fl);
        ent_t ea, eb;
        if_valid_instA_in = a;  if_valid_instB_in = b;
        if_IRA_in = ia;         if_IRB_in = ib;
        if_PCA_in = pa;         if_PCB_in = pb;
        id_take_cnt_in = 2'(take);
        flush_in = fl;
        ea.inst = ia; ea.pc = pa;
        eb.inst = ib; eb.pc = pb;
        mdl_edge(a, b, ea, eb, take, fl);
        @(posedge clock);
        exp_q.push_back(mdl_snap());
        #1;
    endtask

    // Offer instructions with sequential PCs and random encodings.
    task automatic offer(input bit a, input bit b, input int take, input bit fl);
        logic [63:0] pa, pb;
        pa = pc_ctr;
        if (a) pc_ctr += 64'd4;
        pb = pc_ctr;
        if (b) pc_ctr += 64'd4;
        step(a, b, $urandom(), $urandom(), pa, pb, take, fl);
    endtask

    task automatic idle_inputs();
        if_valid_instA_in = 1'b0; if_valid_instB_in = 1'b0;
        if_IRA_in = '0; if_IRB_in = '0; if_PCA_in = '0; if_PCB_in = '0;
        id_take_cnt_in = 2'd0;
        flush_in = 1'b0;
    endtask

    // Reset pulse entirely between clock edges: clearing must not wait for an edge.
    task automatic reset_pulse();
        @(negedge clock);
        idle_inputs();
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        mdl_q.delete();
        mdl_ovf = 1'b0;
        exp_q.push_back(mdl_snap());
        @(posedge clock);
        #1;
    endtask

    // Monitor: compare DUT outputs against the oldest pending expectation.
    initial begin
        snap_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("validA", 64'(ib_valid_instA_out), 64'(e.va));
                chk("validB", 64'(ib_valid_instB_out), 64'(e.vb));
                chk("IRA",    64'(ib_IRA_out),         64'(e.ira));
                chk("IRB",    64'(ib_IRB_out),         64'(e.irb));
                chk("PCA",    ib_PCA_out,              e.pca);
                chk("PCB",    ib_PCB_out,              e.pcb);
                chk("non_ins_en", 64'(non_ins_en_out), 64'(e.non));
                chk("one_ins_en", 64'(one_ins_en_out), 64'(e.one));
                chk("overflow_err", 64'(overflow_err_out), 64'(e.ovf));
            end
        end
    end

    initial begin
        idle_inputs();
        reset   = 1'b1;
        mdl_ovf = 1'b0;
        exp_q.push_back(mdl_snap());
        @(negedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        exp_q.push_back(mdl_snap());
        #1;

        // Pair at PC 0x0/0x4, then fill through counts 3,5,7,8 and over-enqueue when full.
        offer(1, 1, 0, 0);
        offer(1, 0, 0, 0);
        offer(1, 1, 0, 0);
        offer(1, 1, 0, 0);
        offer(1, 0, 0, 0);
        offer(1, 1, 0, 0);

        // Clear, then steady two-in/two-out across pointer wrap.
        reset_pulse();
        offer(1, 1, 0, 0);
        repeat (20) offer(1, 1, 2, 0);

        // Flush, then a lone B into an empty buffer.
        offer(0, 0, 0, 1);
        pc_ctr = 64'h10;
        offer(0, 1, 0, 0);

        // Build count 5, then flush with a simultaneous enqueue.
        offer(1, 1, 0, 0);
        offer(1, 1, 0, 0);
        offer(1, 1, 1, 1);

        // Take more than present, then an asynchronous reset pulse with content.
        offer(1, 0, 0, 0);
        offer(0, 0, 2, 0);
        offer(1, 1, 0, 0);
        reset_pulse();

        // Random traffic; IF mostly honours the throttles.
        for (int i = 0; i < 400; i++) begin
            int n;
            bit a, b;
            n = mdl_q.size();
            a = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) != 0) begin
                if (n == DEPTH) begin
                    a = 1'b0;
                    b = 1'b0;
                end else if (n == DEPTH - 1 && a && b) begin
                    b = 1'b0;
                end
            end
            if (i == 200) reset_pulse();
            offer(a, b, $urandom_range(0, 3), $urandom_range(0, 29) == 0);
        end

        idle_inputs();
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
